sram_bus_arbiter: RTL and testbench

Arbitrates between the instruction-fetch requester and the data-memory requester (EX issues loads/stores, MEM consumes read data) for a single shared SRAM-like bus with split address/data handshakes. It tracks which requester owns each outstanding transaction, so in-order `data_ok`/`rdata` returns reach the correct stage. It sits between the pipeline stages and the bus bridge/memory.

---
 rtl/sram_bus_pkg.sv | 26 ++
 rtl/sram_bus_arbiter_if.sv | 24 ++
 rtl/owner_fifo.sv | 74 +++++++
 rtl/sram_bus_arbiter.sv | 104 ++++++++++
 tb/tb_sram_bus_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bus_pkg.sv
// Shared types for the SRAM-like bus arbiter.
//   owner_e : which requester owns a transaction (INST=0, DATA=1)
//   size_e  : transfer size encodings (BYTE/HALF/WORD)
//   req_t   : packed request fields {wr, size, wstrb, addr, wdata}, 71 bits
package sram_bus_pkg;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// One SRAM-like port with split address/data handshakes.
//   master: drives req/wr/size/wstrb/addr/wdata, receives addr_ok/data_ok/rdata
//   slave : the opposite direction
interface sram_bus_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/owner_fifo.sv
// In-order FIFO of 1-bit owner IDs for outstanding bus transactions.
//   clk, reset      : clock, synchronous active-high reset
//   push_i, owner_i : enqueue owner_i (ignored when full)
//   pop_i           : dequeue head (ignored when empty)
//   full_o, empty_o : occupancy flags
//   head_o          : owner at the head of the queue
module owner_fifo
    import sram_bus_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_i,
    input  owner_e owner_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output owner_e head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = owner_e'(mem_q[rd_ptr_q]);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= owner_i;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the instruction-fetch and data-memory requesters onto one shared
// SRAM-like bus and routes in-order responses back to the owning requester.
//   clk, reset  : clock, synchronous active-high reset
//   inst_if     : instruction-side requester (slave modport)
//   data_if     : data-side requester (slave modport)
//   bus_if      : shared bus toward bridge/memory (master modport)
//   proto_err_o : sticky, bus_data_ok seen with nothing outstanding
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    sram_bus_arbiter_if.slave         inst_if,
    sram_bus_arbiter_if.slave         data_if,
    sram_bus_arbiter_if.master        bus_if,
    output logic                      proto_err_o
);

    owner_e grant;
    owner_e lock_owner_q, lock_owner_d;
    owner_e head;
    logic   lock_q, lock_d;
    logic   proto_err_q, proto_err_d;
    logic   gnt_req, full, empty, handshake, resp_valid;
    req_t   inst_fields, data_fields, bus_fields;

    assign inst_fields = '{wr: inst_if.wr, size: inst_if.size, wstrb: inst_if.wstrb,
                           addr: inst_if.addr, wdata: inst_if.wdata};
    assign data_fields = '{wr: data_if.wr, size: data_if.size, wstrb: data_if.wstrb,
                           addr: data_if.addr, wdata: data_if.wdata};

    // A locked grant stays with its owner until its address handshake lands.
    always_comb begin
        if (lock_q) begin
            grant = lock_owner_q;
        end else if (data_if.req) begin
            grant = DATA;
        end else begin
            grant = INST;
        end
    end

    assign gnt_req    = (grant == DATA) ? data_if.req : inst_if.req;
    assign bus_fields = (grant == DATA) ? data_fields : inst_fields;

    assign bus_if.req   = gnt_req & ~full & ~reset;
    assign bus_if.wr    = bus_fields.wr;
    assign bus_if.size  = bus_fields.size;
    assign bus_if.wstrb = bus_fields.wstrb;
    assign bus_if.addr  = bus_fields.addr;
    assign bus_if.wdata = bus_fields.wdata;

    assign handshake       = bus_if.req & bus_if.addr_ok;
    assign inst_if.addr_ok = handshake & (grant == INST);
    assign data_if.addr_ok = handshake & (grant == DATA);

    assign resp_valid      = bus_if.data_ok & ~empty & ~reset;
    assign inst_if.data_ok = resp_valid & (head == INST);
    assign data_if.data_ok = resp_valid & (head == DATA);
    assign inst_if.rdata   = bus_if.rdata;
    assign data_if.rdata   = bus_if.rdata;

    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        if (handshake) begin
            lock_d = 1'b0;
        end else if (bus_if.req) begin
            lock_d       = 1'b1;
            lock_owner_d = grant;
        end
        proto_err_d = proto_err_q | (bus_if.data_ok & empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= INST;
            proto_err_q  <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign proto_err_o = proto_err_q;

    owner_fifo #(
        .Depth (OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (handshake),
        .owner_i (grant),
        .pop_i   (resp_valid),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench with a response scoreboard: stimulus pushes the expected
// {owner, rdata} for each accepted transaction; a negedge monitor pops and
// compares whenever either data_ok is presented.
module tb_sram_bus_arbiter;
    import sram_bus_pkg::*;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    logic proto_err;
    int   checks = 0;
    int   failures = 0;
    resp_t exp_q[$];

    sram_bus_arbiter_if inst_if ();
    sram_bus_arbiter_if data_if ();
    sram_bus_arbiter_if bus_if ();

    sram_bus_arbiter #(
        .OUTSTANDING (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inst_if     (inst_if),
        .data_if     (data_if),
        .bus_if      (bus_if),
        .proto_err_o (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input owner_e o, input logic [31:0] d);
        exp_q.push_back('{owner: o, rdata: d});
    endtask

    task automatic data_ok_pulse(input logic [31:0] d);
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = d;
        cyc();
        bus_if.data_ok = 1'b0;
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (!reset && (inst_if.data_ok || data_if.data_ok)) begin
            resp_t e;
            logic  got_owner;
            logic [31:0] got_data;
            got_owner = data_if.data_ok;
            got_data  = data_if.data_ok ? data_if.rdata : inst_if.rdata;
            chk("both_data_ok", {31'd0, inst_if.data_ok & data_if.data_ok}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_data_ok", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_owner", {31'd0, got_owner}, {31'd0, e.owner});
                chk("resp_rdata", got_data, e.rdata);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = WORD; inst_if.wstrb = 4'hf;
        inst_if.addr = 0; inst_if.wdata = 0;
        data_if.req = 0; data_if.wr = 0; data_if.size = WORD; data_if.wstrb = 4'hf;
        data_if.addr = 0; data_if.wdata = 0;
        bus_if.addr_ok = 0; bus_if.data_ok = 0; bus_if.rdata = 0;
        cyc(); cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_bus_req", {31'd0, bus_if.req}, 32'd0);
        chk("reset_proto_err", {31'd0, proto_err}, 32'd0);

        // Both request together: data first, inst next cycle.
        cyc();
        inst_if.req = 1; inst_if.addr = 32'h1000;
        data_if.req = 1; data_if.addr = 32'h2000; data_if.wr = 1; data_if.wdata = 32'h5a5a;
        bus_if.addr_ok = 1;
        @(negedge clk);
        chk("t1_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd1);
        chk("t1_inst_addr_ok0", {31'd0, inst_if.addr_ok}, 32'd0);
        chk("t1_bus_addr_data", bus_if.addr, 32'h2000);
        chk("t1_bus_wr_data", {31'd0, bus_if.wr}, 32'd1);
        expect_resp(DATA, 32'h1111_1111);
        cyc();
        data_if.req = 0; data_if.wr = 0;
        @(negedge clk);
        chk("t1_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd1);
        chk("t1_bus_addr_inst", bus_if.addr, 32'h1000);
        expect_resp(INST, 32'h2222_2222);
        cyc();
        inst_if.req = 0; bus_if.addr_ok = 0;
        data_ok_pulse(32'h1111_1111);
        data_ok_pulse(32'h2222_2222);

        // Inst stalls 3 cycles; data arriving later must not steal the grant.
        inst_if.req = 1; inst_if.addr = 32'h3000;
        @(negedge clk);
        chk("t2_c0_bus_req", {31'd0, bus_if.req}, 32'd1);
        cyc();
        data_if.req = 1; data_if.addr = 32'h4000;
        @(negedge clk);
        chk("t2_c1_locked_addr", bus_if.addr, 32'h3000);
        chk("t2_c1_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd0);
        cyc();
        @(negedge clk);
        chk("t2_c2_locked_addr", bus_if.addr, 32'h3000);
        cyc();
        bus_if.addr_ok = 1;
        @(negedge clk);
        chk("t2_c3_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd1);
        chk("t2_c3_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd0);
        expect_resp(INST, 32'h3333_3333);
        cyc();
        inst_if.req = 0;
        @(negedge clk);
        chk("t2_c4_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd1);
        chk("t2_c4_bus_addr", bus_if.addr, 32'h4000);
        expect_resp(DATA, 32'h4444_4444);
        cyc();
        data_if.req = 0; bus_if.addr_ok = 0;
        data_ok_pulse(32'h3333_3333);
        data_ok_pulse(32'h4444_4444);

        // Three loads into a depth-2 FIFO; third waits for a pop, then one more cycle.
        bus_if.addr_ok = 1;
        data_if.req = 1; data_if.addr = 32'h100;
        @(negedge clk);
        chk("t3_ld0_ok", {31'd0, data_if.addr_ok}, 32'd1);
        expect_resp(DATA, 32'hAAAA_0000);
        cyc();
        data_if.addr = 32'h104;
        @(negedge clk);
        chk("t3_ld1_ok", {31'd0, data_if.addr_ok}, 32'd1);
        expect_resp(DATA, 32'hBBBB_0000);
        cyc();
        data_if.addr = 32'h108;
        @(negedge clk);
        chk("t3_full_bus_req", {31'd0, bus_if.req}, 32'd0);
        chk("t3_full_addr_ok", {31'd0, data_if.addr_ok}, 32'd0);
        cyc();
        bus_if.data_ok = 1; bus_if.rdata = 32'hAAAA_0000;
        @(negedge clk);
        chk("t3_pop_cycle_bus_req", {31'd0, bus_if.req}, 32'd0);
        chk("t3_pop_cycle_addr_ok", {31'd0, data_if.addr_ok}, 32'd0);
        cyc();
        bus_if.data_ok = 0;
        @(negedge clk);
        chk("t3_ld2_ok", {31'd0, data_if.addr_ok}, 32'd1);
        chk("t3_ld2_addr", bus_if.addr, 32'h108);
        expect_resp(DATA, 32'hCCCC_0000);
        cyc();
        data_if.req = 0; bus_if.addr_ok = 0;
        data_ok_pulse(32'hBBBB_0000);
        data_ok_pulse(32'hCCCC_0000);

        // data_ok with nothing outstanding.
        bus_if.data_ok = 1; bus_if.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t5_no_inst_data_ok", {31'd0, inst_if.data_ok}, 32'd0);
        chk("t5_no_data_data_ok", {31'd0, data_if.data_ok}, 32'd0);
        chk("t5_proto_err_pre", {31'd0, proto_err}, 32'd0);
        cyc();
        bus_if.data_ok = 0;
        @(negedge clk);
        chk("t5_proto_err_set", {31'd0, proto_err}, 32'd1);
        cyc(); cyc();
        @(negedge clk);
        chk("t5_proto_err_sticky", {31'd0, proto_err}, 32'd1);

        // Reset with outstanding work and the inst side locked.
        bus_if.addr_ok = 1;
        data_if.req = 1; data_if.addr = 32'h7000;
        cyc();
        data_if.req = 0; inst_if.req = 1; inst_if.addr = 32'h5000; bus_if.addr_ok = 0;
        cyc();
        data_if.req = 1; data_if.addr = 32'h7004;
        @(negedge clk);
        chk("t6_locked_inst", bus_if.addr, 32'h5000);
        cyc();
        reset = 1; bus_if.addr_ok = 1; bus_if.data_ok = 1;
        @(negedge clk);
        chk("t6_rst_bus_req", {31'd0, bus_if.req}, 32'd0);
        chk("t6_rst_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd0);
        chk("t6_rst_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd0);
        chk("t6_rst_data_ok", {31'd0, inst_if.data_ok | data_if.data_ok}, 32'd0);
        cyc();
        reset = 0; bus_if.data_ok = 0; inst_if.req = 0; data_if.addr = 32'h6000;
        @(negedge clk);
        chk("t6_post_rst_accept", {31'd0, data_if.addr_ok}, 32'd1);
        chk("t6_post_rst_proto", {31'd0, proto_err}, 32'd0);
        expect_resp(DATA, 32'h6666_0000);
        cyc();
        data_if.addr = 32'h6004;
        @(negedge clk);
        chk("t6_second_accept", {31'd0, data_if.addr_ok}, 32'd1);
        expect_resp(DATA, 32'h6666_0004);
        cyc();
        data_if.addr = 32'h6008;
        @(negedge clk);
        chk("t6_count_restarted_full", {31'd0, bus_if.req}, 32'd0);
        cyc();
        data_if.req = 0; bus_if.addr_ok = 0;
        data_ok_pulse(32'h6666_0000);
        data_ok_pulse(32'h6666_0004);
        cyc();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
